// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the accumulator-CPU microsequencer: opcodes, T-state codes, control word.
// The optional single-step input is enabled by the CPU_CTRL_STEP_EN macro in cpu_ctrl_seq.
package cpu_ctrl_pkg;

  localparam int OP_W = 4;
  localparam int TS_W = 3;

  localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OP_W-1:0] OP_LDA = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0011;
  localparam logic [OP_W-1:0] OP_STA = 4'b0100;
  localparam logic [OP_W-1:0] OP_LDI = 4'b0101;
  localparam logic [OP_W-1:0] OP_JMP = 4'b0110;
  localparam logic [OP_W-1:0] OP_JC  = 4'b0111;
  localparam logic [OP_W-1:0] OP_JZ  = 4'b1000;
  localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  typedef enum logic [TS_W-1:0] {
    T0     = 3'd0,
    T1     = 3'd1,
    T2     = 3'd2,
    T3     = 3'd3,
    T4     = 3'd4,
    T_HALT = 3'd5
  } tstate_e;

  // flag_cap and hlt are internal requests to the top; they never leave the sequencer.
  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ram_load;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_cut;
    logic out_load;
    logic flag_cap;
    logic hlt;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational microcode decoder: (T-state, opcode, flags) -> control word plus last-step flag.
// HALT and unreachable T-states decode to an all-zero control word.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  tstate_e         t_state_i,
  input  logic [OP_W-1:0] opcode_i,
  input  logic            flag_cy_i,
  input  logic            flag_z_i,
  output ctrl_t           ctrl_o,
  output logic            last_o
);

  always_comb begin
    ctrl_o = CTRL_IDLE;
    last_o = 1'b0;
    case (t_state_i)
      T0: begin
        ctrl_o.pc_out   = 1'b1;
        ctrl_o.mar_load = 1'b1;
      end
      T1: begin
        ctrl_o.ram_out = 1'b1;
        ctrl_o.ir_load = 1'b1;
        ctrl_o.pc_inc  = 1'b1;
      end
      T2: begin
        last_o = 1'b1;
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl_o.ir_out   = 1'b1;
            ctrl_o.mar_load = 1'b1;
            last_o          = 1'b0;
          end
          OP_LDI: begin
            ctrl_o.ir_out = 1'b1;
            ctrl_o.a_load = 1'b1;
          end
          OP_JMP: begin
            ctrl_o.ir_out  = 1'b1;
            ctrl_o.pc_load = 1'b1;
          end
          // Conditional jumps look only at the registered flags.
          OP_JC: begin
            ctrl_o.ir_out  = 1'b1;
            ctrl_o.pc_load = flag_cy_i;
          end
          OP_JZ: begin
            ctrl_o.ir_out  = 1'b1;
            ctrl_o.pc_load = flag_z_i;
          end
          OP_OUT: begin
            ctrl_o.a_out    = 1'b1;
            ctrl_o.out_load = 1'b1;
          end
          OP_HLT:  ctrl_o.hlt = 1'b1;
          default: ;
        endcase
      end
      T3: begin
        last_o = 1'b1;
        case (opcode_i)
          OP_LDA: begin
            ctrl_o.ram_out = 1'b1;
            ctrl_o.a_load  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl_o.ram_out = 1'b1;
            ctrl_o.b_load  = 1'b1;
            last_o         = 1'b0;
          end
          OP_STA: begin
            ctrl_o.a_out    = 1'b1;
            ctrl_o.ram_load = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        last_o = 1'b1;
        if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          ctrl_o.alu_out  = 1'b1;
          ctrl_o.a_load   = 1'b1;
          ctrl_o.flag_cap = 1'b1;
          ctrl_o.alu_cut  = (opcode_i == OP_SUB);
        end
      end
      default: last_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Microsequencer top: T-state register, flag register, sticky halt and strobe gating.
// Defining CPU_CTRL_STEP_EN adds a 'step' input that advances one micro-step per pulse.
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = OP_W,
  parameter int TSTATE_W = TS_W
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef CPU_CTRL_STEP_EN
  input  logic                step,
`endif
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                alu_cy,
  input  logic                alu_z,
  output logic                pc_out,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                mar_load,
  output logic                ram_out,
  output logic                ram_load,
  output logic                ir_load,
  output logic                ir_out,
  output logic                a_load,
  output logic                a_out,
  output logic                b_load,
  output logic                alu_out,
  output logic                alu_cut,
  output logic                out_load,
  output logic                flag_cy,
  output logic                flag_z,
  output logic                halt,
  output logic [TSTATE_W-1:0] t_state
);

  tstate_e state_q, state_d;
  logic    flag_cy_q, flag_cy_d;
  logic    flag_z_q, flag_z_d;
  ctrl_t   ctrl, ctrl_gated;
  logic    last;
  logic    adv;

`ifdef CPU_CTRL_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  cpu_ctrl_decode u_decode (
    .t_state_i (state_q),
    .opcode_i  (ir_opcode),
    .flag_cy_i (flag_cy_q),
    .flag_z_i  (flag_z_q),
    .ctrl_o    (ctrl),
    .last_o    (last)
  );

  always_comb begin
    state_d   = state_q;
    flag_cy_d = flag_cy_q;
    flag_z_d  = flag_z_q;
    case (state_q)
      T0:      if (adv) state_d = T1;
      T1:      if (adv) state_d = T2;
      T2:      if (adv) state_d = ctrl.hlt ? T_HALT : (last ? T0 : T3);
      T3:      if (adv) state_d = last ? T0 : T4;
      T4:      if (adv) state_d = T0;
      T_HALT:  state_d = T_HALT;
      default: state_d = T0;
    endcase
    if (adv && ctrl.flag_cap) begin
      flag_cy_d = alu_cy;
      flag_z_d  = alu_z;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= T0;
      flag_cy_q <= 1'b0;
      flag_z_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      flag_cy_q <= flag_cy_d;
      flag_z_q  <= flag_z_d;
    end
  end

  // Strobes drop immediately on reset, not at the next edge.
  assign ctrl_gated = (rst_n && adv) ? ctrl : CTRL_IDLE;

  assign pc_out   = ctrl_gated.pc_out;
  assign pc_inc   = ctrl_gated.pc_inc;
  assign pc_load  = ctrl_gated.pc_load;
  assign mar_load = ctrl_gated.mar_load;
  assign ram_out  = ctrl_gated.ram_out;
  assign ram_load = ctrl_gated.ram_load;
  assign ir_load  = ctrl_gated.ir_load;
  assign ir_out   = ctrl_gated.ir_out;
  assign a_load   = ctrl_gated.a_load;
  assign a_out    = ctrl_gated.a_out;
  assign b_load   = ctrl_gated.b_load;
  assign alu_out  = ctrl_gated.alu_out;
  assign alu_cut  = ctrl_gated.alu_cut;
  assign out_load = ctrl_gated.out_load;

  assign flag_cy = flag_cy_q;
  assign flag_z  = flag_z_q;
  assign halt    = (state_q == T_HALT);
  assign t_state = state_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_cpu_ctrl_seq;

  localparam logic [13:0] PCO  = 14'h2000, PCI  = 14'h1000, PCL  = 14'h0800, MAR  = 14'h0400;
  localparam logic [13:0] RAMO = 14'h0200, RAML = 14'h0100, IRL  = 14'h0080, IRO  = 14'h0040;
  localparam logic [13:0] AL   = 14'h0020, AO   = 14'h0010, BL   = 14'h0008, ALUO = 14'h0004;
  localparam logic [13:0] CUT  = 14'h0002, OUTL = 14'h0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ir_opcode = 4'd0;
  logic       alu_cy = 1'b0, alu_z = 1'b0;
  logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out;
  logic       a_load, a_out, b_load, alu_out, alu_cut, out_load;
  logic       flag_cy, flag_z, halt;
  logic [2:0] t_state;
`ifdef CPU_CTRL_STEP_EN
  logic       step = 1'b1;
`endif

  always #5 clk = ~clk;

  cpu_ctrl_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CPU_CTRL_STEP_EN
    .step      (step),
`endif
    .ir_opcode (ir_opcode),
    .alu_cy    (alu_cy),
    .alu_z     (alu_z),
    .pc_out    (pc_out),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .mar_load  (mar_load),
    .ram_out   (ram_out),
    .ram_load  (ram_load),
    .ir_load   (ir_load),
    .ir_out    (ir_out),
    .a_load    (a_load),
    .a_out     (a_out),
    .b_load    (b_load),
    .alu_out   (alu_out),
    .alu_cut   (alu_cut),
    .out_load  (out_load),
    .flag_cy   (flag_cy),
    .flag_z    (flag_z),
    .halt      (halt),
    .t_state   (t_state)
  );

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [13:0] sb;
    logic       fcy;
    logic       fz;
    logic       hlt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic efcy = 1'b0, efz = 1'b0;

  logic [13:0] sb_act;
  logic [4:0]  bus_act;
  assign sb_act  = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load,
                    ir_out, a_load, a_out, b_load, alu_out, alu_cut, out_load};
  assign bus_act = {pc_out, ram_out, ir_out, a_out, alu_out};

  always @(negedge clk) begin
    exp_t e;
    n_chk++;
    assert ($countones(bus_act) <= 1)
    else begin
      n_fail++;
      $display("FAIL bus_onehot: drivers=%b, required at most one set", bus_act);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if ({t_state, sb_act, flag_cy, flag_z, halt} !== {e.st, e.sb, e.fcy, e.fz, e.hlt}) begin
        n_fail++;
        $display("FAIL %s: got t=%0d sb=%h cy=%b z=%b halt=%b, want t=%0d sb=%h cy=%b z=%b halt=%b",
                 e.name, t_state, sb_act, flag_cy, flag_z, halt, e.st, e.sb, e.fcy, e.fz, e.hlt);
      end
    end
  end

  task automatic cyc(input string nm, input logic rst, input logic [3:0] op, input logic cy,
                     input logic z, input logic [2:0] st, input logic [13:0] sb, input logic hlt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = rst;
    ir_opcode = op;
    alu_cy    = cy;
    alu_z     = z;
    e.name = nm;
    e.st   = st;
    e.sb   = sb;
    e.fcy  = efcy;
    e.fz   = efz;
    e.hlt  = hlt;
    q.push_back(e);
  endtask

  task automatic run_instr(input string nm, input logic [3:0] op, input int n,
                           input logic [13:0] s2, input logic [13:0] s3, input logic [13:0] s4,
                           input logic cy4, input logic z4);
    cyc({nm, ".T0"}, 1'b1, op, 1'b0, 1'b0, 3'd0, PCO | MAR, 1'b0);
    cyc({nm, ".T1"}, 1'b1, op, 1'b0, 1'b0, 3'd1, RAMO | IRL | PCI, 1'b0);
    cyc({nm, ".T2"}, 1'b1, op, 1'b0, 1'b0, 3'd2, s2, 1'b0);
    if (n > 3) cyc({nm, ".T3"}, 1'b1, op, 1'b0, 1'b0, 3'd3, s3, 1'b0);
    if (n > 4) cyc({nm, ".T4"}, 1'b1, op, cy4, z4, 3'd4, s4, 1'b0);
  endtask

  initial begin
    cyc("reset", 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 14'h0, 1'b0);
    cyc("reset_hold", 1'b0, 4'h5, 1'b1, 1'b1, 3'd0, 14'h0, 1'b0);

    run_instr("LDI", 4'b0101, 3, IRO | AL, 14'h0, 14'h0, 1'b0, 1'b0);
    run_instr("ADD", 4'b0010, 5, IRO | MAR, RAMO | BL, ALUO | AL, 1'b1, 1'b0);
    efcy = 1'b1; efz = 1'b0;
    run_instr("JC_taken", 4'b0111, 3, IRO | PCL, 14'h0, 14'h0, 1'b0, 1'b0);
    run_instr("SUB", 4'b0011, 5, IRO | MAR, RAMO | BL, ALUO | AL | CUT, 1'b0, 1'b1);
    efcy = 1'b0; efz = 1'b1;
    run_instr("JZ_taken", 4'b1000, 3, IRO | PCL, 14'h0, 14'h0, 1'b0, 1'b0);
    run_instr("JC_not", 4'b0111, 3, IRO, 14'h0, 14'h0, 1'b0, 1'b0);
    run_instr("STA", 4'b0100, 4, IRO | MAR, AO | RAML, 14'h0, 1'b0, 1'b0);
    run_instr("LDA", 4'b0001, 4, IRO | MAR, RAMO | AL, 14'h0, 1'b0, 1'b0);
    run_instr("JMP", 4'b0110, 3, IRO | PCL, 14'h0, 14'h0, 1'b0, 1'b0);
    run_instr("OUT", 4'b1110, 3, AO | OUTL, 14'h0, 14'h0, 1'b0, 1'b0);
    run_instr("NOP", 4'b0000, 3, 14'h0, 14'h0, 14'h0, 1'b0, 1'b0);
    for (int op = 9; op <= 13; op++)
      run_instr($sformatf("NOP_%0d", op), 4'(op), 3, 14'h0, 14'h0, 14'h0, 1'b0, 1'b0);
    run_instr("ADD_nz", 4'b0010, 5, IRO | MAR, RAMO | BL, ALUO | AL, 1'b0, 1'b0);
    efcy = 1'b0; efz = 1'b0;
    run_instr("JZ_not", 4'b1000, 3, IRO, 14'h0, 14'h0, 1'b0, 1'b0);
    run_instr("SUB_cz", 4'b0011, 5, IRO | MAR, RAMO | BL, ALUO | AL | CUT, 1'b1, 1'b1);
    efcy = 1'b1; efz = 1'b1;

    run_instr("HLT", 4'b1111, 3, 14'h0, 14'h0, 14'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc($sformatf("HALT_%0d", i), 1'b1, 4'(i), i[0], i[1], 3'd5, 14'h0, 1'b1);

    // Reset asserted between edges: state, flags and halt must clear before any clock edge.
    efcy = 1'b0; efz = 1'b0;
    cyc("async_rst", 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 14'h0, 1'b0);
    run_instr("LDI_after_rst", 4'b0101, 3, IRO | AL, 14'h0, 14'h0, 1'b0, 1'b0);

    // Free-running opcode stream; only the single-bus-driver rule is checked here.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (t_state == 3'd0) ir_opcode = 4'($urandom_range(0, 14));
      alu_cy = 1'($urandom_range(0, 1));
      alu_z  = 1'($urandom_range(0, 1));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
